uint32_kbd: RTL and testbench

Hex keypad scanner that is the input-side counterpart of the board's 8-digit multiplexed 32-bit display. It strobes the four columns of a 4x4 hex key matrix, samples the rows, debounces complete scans and converts each clean single-key press into a 4-bit code. Each code is shifted into a 32-bit entry register, so the value typed on the keypad can be shown directly on the display and read by the MCS-51 core.

---
 rtl/uint32_kbd_if.sv | 31 +++
 rtl/uint32_kbd.sv | 180 ++++++++++++++++++
 tb/tb_uint32_kbd.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uint32_kbd_if.sv
// ---------------------------------------------------------------------------
// uint32_kbd_if
// Signal bundle between the hex keypad scanner and its surroundings (key
// matrix, display, MCS-51 core).
//   rows    4  matrix row sense, active-high, asynchronous to the clock
//   clr     1  synchronous clear of the entry register
//   cols    4  one-hot column strobe, active-high
//   key     4  code of the last accepted key
//   key_stb 1  one-cycle pulse per accepted key
//   data   32  entry register, newest key in [3:0]
// slave  : the scanner side (drives cols/key/key_stb/data).
// master : the environment side (drives rows/clr).
// ---------------------------------------------------------------------------
interface uint32_kbd_if;
  logic [3:0]  rows;
  logic        clr;
  logic [3:0]  cols;
  logic [3:0]  key;
  logic        key_stb;
  logic [31:0] data;

  modport slave (
    input  rows, clr,
    output cols, key, key_stb, data
  );

  modport master (
    output rows, clr,
    input  cols, key, key_stb, data
  );
endinterface

// File: rtl/uint32_kbd.sv
// ---------------------------------------------------------------------------
// uint32_kbd
// 4x4 hex keypad scanner. Strobes one column at a time, snapshots the rows at
// the end of each column dwell, debounces whole-matrix scans and turns each
// clean single-key press into a 4-bit code that is shifted into a 32-bit
// entry register.
// Parameters:
//   SCAN_DIV  clocks each column stays strobed (>= 4)
//   DEBOUNCE  identical complete scans needed to accept a new state (>= 1)
// Ports:
//   CLK   system clock, rising edge
//   nRST  asynchronous active-low reset
//   bus   uint32_kbd_if.slave (rows, clr in; cols, key, key_stb, data out)
// ---------------------------------------------------------------------------
module uint32_kbd #(
  parameter int SCAN_DIV = 1024,
  parameter int DEBOUNCE = 4
) (
  input logic          CLK,
  input logic          nRST,
  uint32_kbd_if.slave  bus
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);
  localparam logic [SW-1:0] STABLE_LD  = SW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  // Scan timing. 'run' holds the strobe off for the reset cycle so that the
  // first edge after reset release shows column 0 for a full dwell.
  logic          run;
  logic [1:0]    col_idx;
  logic [DW-1:0] dwell;

  // Row synchronizer and scan bookkeeping.
  logic [3:0]    rows_s1, rows_s2;
  logic [15:0]   snap, prev;
  logic [SW-1:0] stable;
  state_t        state_q, state_d;

  logic [3:0]    key_q;
  logic          stb_q;
  logic [31:0]   data_q;

  // Combinational helpers.
  logic          dwell_end, scan_end, same, deb_load, accept;
  logic [15:0]   snap_new;
  logic [4:0]    ones;
  logic [3:0]    code;

  assign bus.cols    = run ? (4'b0001 << col_idx) : 4'b0000;
  assign bus.key     = key_q;
  assign bus.key_stb = stb_q;
  assign bus.data    = data_q;

  // NOTE: every combinational output gets a default before any branch;
  // a path that leaves a variable unassigned would infer a latch.
  always_comb begin
    dwell_end = run && (dwell == DWELL_LAST);
    scan_end  = dwell_end && (col_idx == 2'd3);
    snap_new  = snap;
    snap_new[{col_idx, 2'b00} +: 4] = rows_s2;
    same      = (snap_new == prev);
    deb_load  = scan_end && same && (stable >= STABLE_LD);
    // Population count and code of the highest set bit; the code is only
    // used when exactly one bit is set.
    ones = 5'd0;
    code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snap_new[i]) begin
        ones = ones + 5'd1;
        code = 4'(i);
      end
    end
  end

  // The FSM consumes the debounced state in the cycle it is loaded, so no
  // separate debounced register is kept.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    if (deb_load) begin
      case (state_q)
        RELEASED: begin
          if (ones == 5'd1) begin
            state_d = PRESSED;
            accept  = 1'b1;
          end else if (ones >= 5'd2) begin
            state_d = LOCKED;
          end
        end
        PRESSED: begin
          if (ones >= 5'd2)      state_d = LOCKED;
          else if (ones == 5'd0) state_d = RELEASED;
        end
        LOCKED: begin
          if (ones == 5'd0) state_d = RELEASED;
        end
        default: state_d = RELEASED;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      run     <= 1'b0;
      col_idx <= 2'd0;
      dwell   <= '0;
    end else begin
      run <= 1'b1;
      if (run) begin
        if (dwell == DWELL_LAST) begin
          dwell   <= '0;
          col_idx <= col_idx + 2'd1;
        end else begin
          dwell <= dwell + DW'(1);
        end
      end
    end
  end

  // Two-flop synchronizer: rows come straight from the switch matrix.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rows_s1 <= 4'd0;
      rows_s2 <= 4'd0;
    end else begin
      rows_s1 <= bus.rows;
      rows_s2 <= rows_s1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      snap    <= 16'd0;
      prev    <= 16'd0;
      stable  <= '0;
      state_q <= RELEASED;
    end else begin
      state_q <= state_d;
      if (dwell_end) snap <= snap_new;
      if (scan_end) begin
        if (same) begin
          if (stable != STABLE_MAX) stable <= stable + SW'(1);
        end else begin
          stable <= '0;
          prev   <= snap_new;
        end
      end
    end
  end

  // Key outputs and entry register. A clear that coincides with an accepted
  // key leaves just that key in the register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      key_q  <= 4'd0;
      stb_q  <= 1'b0;
      data_q <= 32'd0;
    end else begin
      stb_q <= accept;
      if (accept) begin
        key_q  <= code;
        data_q <= bus.clr ? {28'd0, code} : {data_q[27:0], code};
      end else if (bus.clr) begin
        data_q <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_uint32_kbd.sv
// ---------------------------------------------------------------------------
// tb_uint32_kbd
// Bench for uint32_kbd with SCAN_DIV = 4, DEBOUNCE = 2 (16-clock scans).
// A key matrix model turns the pressed-key mask and the column strobe into
// row levels. Expected key/data pairs are queued when a press is issued and
// checked by a monitor whenever key_stb is seen.
// ---------------------------------------------------------------------------
module tb_uint32_kbd;

  localparam int SCAN = 16;

  logic        clk;
  logic        nrst;
  logic [15:0] press;

  uint32_kbd_if bus();

  uint32_kbd #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: row r is high when a pressed key in the strobed column sits
  // on that row.
  always_comb begin
    bus.rows = 4'd0;
    for (int r = 0; r < 4; r++) begin
      bus.rows[r] = (press[r]      & bus.cols[0]) |
                    (press[4 + r]  & bus.cols[1]) |
                    (press[8 + r]  & bus.cols[2]) |
                    (press[12 + r] & bus.cols[3]);
    end
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_stb = 0;
  logic [35:0] sb_q[$];
  logic [31:0] exp_data = 32'd0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (nrst && bus.key_stb) begin
      logic [35:0] e;
      n_stb++;
      if (sb_q.size() == 0) begin
        check("strobe_expected", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("sb_key", {28'd0, bus.key}, {28'd0, e[35:32]});
        check("sb_data", bus.data, e[31:0]);
      end
    end
  end

  task automatic sb_push(input logic [3:0] code);
    exp_data = {exp_data[27:0], code};
    sb_q.push_back({code, exp_data});
  endtask

  // Leaves the bench #1 after the edge that starts column 0 of a new scan.
  task automatic align();
    int n = 0;
    do begin @(posedge clk); #1; n++; end
    while (bus.cols != 4'b1000 && n < 100);
    do begin @(posedge clk); #1; n++; end
    while (bus.cols != 4'b0001 && n < 100);
    if (n >= 100) check("align_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_strobe(input string name, input int exp_cyc);
    int n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!bus.key_stb && n < 300);
    check(name, 32'(n), 32'(exp_cyc));
  endtask

  // Press one key from a scan start, hold it, release, let release settle.
  task automatic enter_key(input logic [3:0] code, input int hold_scans);
    align();
    press = 16'd1 << code;
    sb_push(code);
    wait_strobe("key_latency", 3 * SCAN);
    repeat (hold_scans * SCAN - 3 * SCAN) @(posedge clk);
    #1 press = 16'd0;
    repeat (4 * SCAN) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
  endtask

  initial begin
    int s0;
    nrst    = 1'b0;
    bus.clr = 1'b0;
    press   = 16'd0;

    // Reset values and strobe sequence after release.
    repeat (3) @(posedge clk); #1;
    check("rst_cols", {28'd0, bus.cols}, 32'd0);
    check("rst_key", {28'd0, bus.key}, 32'd0);
    check("rst_stb", {31'd0, bus.key_stb}, 32'd0);
    check("rst_data", bus.data, 32'd0);
    nrst = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk); #1;
      if (i % 4 == 1)
        check("scan_cols", {28'd0, bus.cols}, 32'd1 << (((i - 1) / 4) % 4));
    end
    // Mid-dwell asynchronous reset, then the sequence restarts at column 0.
    repeat (2) @(posedge clk);
    #3 nrst = 1'b0;
    #1 check("async_rst_cols", {28'd0, bus.cols}, 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk); #1;
      if (i % 4 == 1)
        check("rescan_cols", {28'd0, bus.cols}, 32'd1 << (((i - 1) / 4) % 4));
    end

    // Single key col2/row1 held for 10 scans.
    s0 = n_stb;
    enter_key(4'h9, 10);
    check("single_cnt", 32'(n_stb - s0), 32'd1);
    check("single_key", {28'd0, bus.key}, 32'h9);
    check("single_data", bus.data, 32'h0000_0009);

    // Plain clear.
    pulse_clr();
    exp_data = 32'd0;
    check("clr_data", bus.data, 32'd0);
    check("clr_key_kept", {28'd0, bus.key}, 32'h9);

    // Keys 1..8 then clear from 0x12345678.
    for (int k = 1; k <= 8; k++) enter_key(4'(k), 4);
    check("entry_8", bus.data, 32'h1234_5678);
    pulse_clr();
    exp_data = 32'd0;
    check("clr_full", bus.data, 32'd0);

    // Clear coinciding with an accepted 0xC (col3/row0).
    align();
    press = 16'd1 << 12;
    exp_data = 32'd0;
    sb_push(4'hC);
    repeat (3 * SCAN - 1) @(posedge clk);
    #1 bus.clr = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
    check("clr_acc_stb", {31'd0, bus.key_stb}, 32'd1);
    check("clr_acc_data", bus.data, 32'h0000_000C);
    press = 16'd0;
    repeat (5 * SCAN) @(posedge clk); #1;

    // Entry wrap: 1..8 then F.
    s0 = n_stb;
    for (int k = 1; k <= 8; k++) enter_key(4'(k), 4);
    enter_key(4'hF, 4);
    check("wrap_cnt", 32'(n_stb - s0), 32'd9);
    check("wrap_data", bus.data, 32'h2345_678F);

    // Bounce on key 0: toggle for 5 scans (on,off,on,off,on), then hold.
    s0 = n_stb;
    align();
    for (int i = 0; i < 5; i++) begin
      press = (i % 2 == 0) ? 16'd1 : 16'd0;
      repeat (SCAN) @(posedge clk);
      #1;
    end
    check("bounce_quiet", 32'(n_stb - s0), 32'd0);
    sb_push(4'h0);
    wait_strobe("bounce_latency", 2 * SCAN);
    repeat (3 * SCAN) @(posedge clk);
    #1 press = 16'd0;
    repeat (4 * SCAN) @(posedge clk); #1;
    check("bounce_cnt", 32'(n_stb - s0), 32'd1);

    // Multi-key lockout: 0x5 + 0xA, release 0xA, release all, then 0x3.
    s0 = n_stb;
    align();
    press = (16'd1 << 5) | (16'd1 << 10);
    repeat (4 * SCAN) @(posedge clk);
    #1 press = 16'd1 << 5;
    repeat (4 * SCAN) @(posedge clk);
    #1 press = 16'd0;
    repeat (4 * SCAN) @(posedge clk); #1;
    check("lock_quiet", 32'(n_stb - s0), 32'd0);
    enter_key(4'h3, 4);
    check("lock_cnt", 32'(n_stb - s0), 32'd1);
    check("lock_key", {28'd0, bus.key}, 32'h3);

    // Reset while running with a non-zero entry register.
    repeat (5) @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    check("late_rst_data", bus.data, 32'd0);
    check("late_rst_key", {28'd0, bus.key}, 32'd0);
    check("late_rst_cols", {28'd0, bus.cols}, 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
